// File: rtl/synth_timing_pkg.sv
// -----------------------------------------------------------------------------
// synth_timing_pkg
// Shared types and helpers for the synthesis timing blocks.
//   trig_state_t   : frame-trigger FSM states
//   ACC_WIDTH_DEF  : default fractional accumulator width
//   CNT_WIDTH_DEF  : default event counter width
//   sat_inc()      : saturating increment for counters up to 32 bits wide
// -----------------------------------------------------------------------------
package synth_timing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    TRIG      = 2'd2,
    BUSY      = 2'd3
  } trig_state_t;

  localparam int ACC_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF = 16;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    if (width >= 32'd32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (val >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/frac_tick_div.sv
// -----------------------------------------------------------------------------
// frac_tick_div
// Fractional-N rate divider: adds SAMPLE_RATE to a phase accumulator every
// enabled cycle and emits a tick whenever the phase wraps past AUDIO_CLK_RATE,
// giving an exact long-term tick rate of SAMPLE_RATE per AUDIO_CLK_RATE cycles.
// Ports:
//   clk     in   clock, posedge
//   rst_n   in   asynchronous active-low reset
//   enable  in   run; 0 clears the accumulator on the next edge
//   tick    out  combinational, high in the cycle whose edge wraps the phase
// -----------------------------------------------------------------------------
module frac_tick_div
  import synth_timing_pkg::*;
#(
  parameter int AUDIO_CLK_RATE = 90416666,
  parameter int SAMPLE_RATE    = 44100,
  parameter int ACC_WIDTH      = ACC_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  // All arithmetic carries one guard bit so acc+SAMPLE_RATE can never overflow.
  localparam logic [ACC_WIDTH:0] SR_W   = (ACC_WIDTH+1)'(SAMPLE_RATE);
  localparam logic [ACC_WIDTH:0] RATE_W = (ACC_WIDTH+1)'(AUDIO_CLK_RATE);

  // acc_r stays below AUDIO_CLK_RATE, so its guard bit is always zero.
  logic [ACC_WIDTH:0] acc_r;
  logic [ACC_WIDTH:0] sum_s;
  logic [ACC_WIDTH:0] acc_next_s;
  logic               wrap_s;

  // Next phase and wrap detection.
  always_comb begin
    sum_s      = acc_r + SR_W;
    wrap_s     = 1'b0;
    acc_next_s = sum_s;
    if (sum_s >= RATE_W) begin
      wrap_s     = 1'b1;
      acc_next_s = sum_s - RATE_W;
    end else begin
      wrap_s     = 1'b0;
      acc_next_s = sum_s;
    end
  end

  assign tick = enable & wrap_s;

  // Phase accumulator register; disabled cycles restart the phase from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {(ACC_WIDTH+1){1'b0}};
    end else if (!enable) begin
      acc_r <= {(ACC_WIDTH+1){1'b0}};
    end else begin
      acc_r <= acc_next_s;
    end
  end

endmodule

// File: rtl/sample_trig_gen.sv
// -----------------------------------------------------------------------------
// sample_trig_gen
// Generates the per-sample trig that starts one synthesis frame in
// synth_clk_gen, tracks frame completion through xxxx_zero, and flags ticks
// that arrive while a frame is still running (overrun) or frames that never
// complete (timeout).
// Ports:
//   AUDIO_CLK      in   clock, posedge
//   reset_reg_N    in   asynchronous active-low reset
//   enable         in   run; 0 returns to IDLE and clears the phase
//   xxxx_zero      in   frame index==0 from synth_clk_gen, asynchronous
//   trig           out  frame start pulse, TRIG_WIDTH cycles high
//   frame_busy     out  high from trig assertion until frame done/timeout
//   overrun_pulse  out  1 cycle: tick dropped because a frame was running
//   timeout_pulse  out  1 cycle: frame exceeded TIMEOUT_CYC cycles
//   overrun_count  out  saturating overrun counter
//   timeout_count  out  saturating timeout counter
// -----------------------------------------------------------------------------
module sample_trig_gen
  import synth_timing_pkg::*;
#(
  parameter int AUDIO_CLK_RATE = 90416666,
  parameter int SAMPLE_RATE    = 44100,
  parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
  parameter int TRIG_WIDTH     = 4,
  parameter int TIMEOUT_CYC    = 4096,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                 AUDIO_CLK,
  input  logic                 reset_reg_N,
  input  logic                 enable,
  input  logic                 xxxx_zero,
  output logic                 trig,
  output logic                 frame_busy,
  output logic                 overrun_pulse,
  output logic                 timeout_pulse,
  output logic [CNT_WIDTH-1:0] overrun_count,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  localparam int TW_W   = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;
  localparam int BUSY_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TW_W-1:0]   TRIG_LAST = TW_W'(TRIG_WIDTH - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT_CYC - 1);

  trig_state_t       state_r;
  logic [TW_W-1:0]   trig_cnt_r;
  logic [BUSY_W-1:0] busy_cnt_r;
  logic              seen_low_r;
  logic              zs_meta_r;
  logic              zs_r;
  logic              tick_s;
  logic              done_s;
  logic              timeout_s;

  frac_tick_div #(
    .AUDIO_CLK_RATE (AUDIO_CLK_RATE),
    .SAMPLE_RATE    (SAMPLE_RATE),
    .ACC_WIDTH      (ACC_WIDTH)
  ) u_frac_tick_div (
    .clk    (AUDIO_CLK),
    .rst_n  (reset_reg_N),
    .enable (enable),
    .tick   (tick_s)
  );

  // Two-flop synchronizer for xxxx_zero; only zs_r is used downstream.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      zs_meta_r <= 1'b0;
      zs_r      <= 1'b0;
    end else begin
      zs_meta_r <= xxxx_zero;
      zs_r      <= zs_meta_r;
    end
  end

  // A frame is done only after the index has been seen leaving zero and
  // returning to it, so a stale high level at trig time is not mistaken for
  // completion. busy_cnt_r counts from TRIG entry, so the frame may occupy
  // TRIG+BUSY for exactly TIMEOUT_CYC cycles.
  assign done_s    = (state_r == BUSY) & zs_r & seen_low_r;
  assign timeout_s = (state_r == BUSY) & (busy_cnt_r == BUSY_LAST) & ~done_s;

  // Frame FSM with registered outputs and saturating event counters.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_r       <= IDLE;
      trig_cnt_r    <= {TW_W{1'b0}};
      busy_cnt_r    <= {BUSY_W{1'b0}};
      seen_low_r    <= 1'b0;
      trig          <= 1'b0;
      frame_busy    <= 1'b0;
      overrun_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      overrun_count <= {CNT_WIDTH{1'b0}};
      timeout_count <= {CNT_WIDTH{1'b0}};
    end else if (!enable) begin
      state_r       <= IDLE;
      trig_cnt_r    <= {TW_W{1'b0}};
      busy_cnt_r    <= {BUSY_W{1'b0}};
      seen_low_r    <= 1'b0;
      trig          <= 1'b0;
      frame_busy    <= 1'b0;
      overrun_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      overrun_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (tick_s) begin
            state_r    <= TRIG;
            trig       <= 1'b1;
            frame_busy <= 1'b1;
            trig_cnt_r <= {TW_W{1'b0}};
            busy_cnt_r <= {BUSY_W{1'b0}};
            seen_low_r <= 1'b0;
          end
        end
        TRIG: begin
          busy_cnt_r <= busy_cnt_r + BUSY_W'(1);
          if (tick_s) begin
            overrun_pulse <= 1'b1;
            overrun_count <= CNT_WIDTH'(sat_inc(32'(overrun_count), CNT_WIDTH));
          end
          if (trig_cnt_r == TRIG_LAST) begin
            state_r <= BUSY;
            trig    <= 1'b0;
          end else begin
            trig_cnt_r <= trig_cnt_r + TW_W'(1);
          end
        end
        BUSY: begin
          if (done_s || timeout_s) begin
            if (timeout_s) begin
              timeout_pulse <= 1'b1;
              timeout_count <= CNT_WIDTH'(sat_inc(32'(timeout_count), CNT_WIDTH));
            end
            // A tick landing on the completion edge starts the next frame
            // straight away rather than being counted as an overrun.
            if (tick_s) begin
              state_r    <= TRIG;
              trig       <= 1'b1;
              frame_busy <= 1'b1;
              trig_cnt_r <= {TW_W{1'b0}};
              busy_cnt_r <= {BUSY_W{1'b0}};
              seen_low_r <= 1'b0;
            end else begin
              state_r    <= WAIT_TICK;
              frame_busy <= 1'b0;
            end
          end else begin
            busy_cnt_r <= busy_cnt_r + BUSY_W'(1);
            if (!zs_r) begin
              seen_low_r <= 1'b1;
            end
            if (tick_s) begin
              overrun_pulse <= 1'b1;
              overrun_count <= CNT_WIDTH'(sat_inc(32'(overrun_count), CNT_WIDTH));
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          trig       <= 1'b0;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
